// File: rtl/datapath_pkg.sv
// datapath_pkg: shared definitions for the two-stage execution datapath.
//   ALU_* : ALU opcode values (opcodes 11..15 are reserved and yield 0).
//   dp_flags_t : result flag bundle {zero, carry, ovf}.
package datapath_pkg;

  localparam int ALU_ADD    = 0;
  localparam int ALU_SUB    = 1;
  localparam int ALU_AND    = 2;
  localparam int ALU_OR     = 3;
  localparam int ALU_XOR    = 4;
  localparam int ALU_SLL    = 5;
  localparam int ALU_SRL    = 6;
  localparam int ALU_SRA    = 7;
  localparam int ALU_SLT    = 8;
  localparam int ALU_SLTU   = 9;
  localparam int ALU_PASS_Y = 10;

  typedef struct packed {
    logic zero;   // result == 0 (forced 0 for reserved opcodes)
    logic carry;  // carry-out (ADD) / not-borrow (SUB)
    logic ovf;    // signed overflow (ADD/SUB)
  } dp_flags_t;

endpackage

// File: rtl/dp_alu.sv
// dp_alu: purely combinational multi-op ALU.
//   op     : ALU opcode (datapath_pkg ALU_*)
//   x, y   : operands
//   result : ALU result
//   flags  : {zero, carry, ovf}
module dp_alu
  import datapath_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] result,
  output dp_flags_t         flags
);

  localparam int SH_W = $clog2(DATA_W);

  logic              is_sub;
  logic [DATA_W-1:0] y_add;
  logic [DATA_W:0]   sum;
  logic [SH_W-1:0]   shamt;
  logic              add_ovf;

  // One adder serves ADD and SUB: SUB is x + ~y + 1.
  assign is_sub  = (int'(op) == ALU_SUB);
  assign y_add   = is_sub ? ~y : y;
  assign sum     = {1'b0, x} + {1'b0, y_add} + {{DATA_W{1'b0}}, is_sub};
  assign shamt   = y[SH_W-1:0];
  // Overflow when both adder inputs share a sign the sum does not.
  assign add_ovf = (x[DATA_W-1] == y_add[DATA_W-1]) && (sum[DATA_W-1] != x[DATA_W-1]);

  always_comb begin
    result      = '0;
    flags       = '0;
    case (int'(op))
      ALU_ADD, ALU_SUB: begin
        result      = sum[DATA_W-1:0];
        flags.carry = sum[DATA_W];
        flags.ovf   = add_ovf;
      end
      ALU_AND:    result = x & y;
      ALU_OR:     result = x | y;
      ALU_XOR:    result = x ^ y;
      ALU_SLL:    result = x << shamt;
      ALU_SRL:    result = x >> shamt;
      ALU_SRA:    result = DATA_W'($signed(x) >>> shamt);
      ALU_SLT:    result = {{(DATA_W-1){1'b0}}, $signed(x) < $signed(y)};
      ALU_SLTU:   result = {{(DATA_W-1){1'b0}}, x < y};
      ALU_PASS_Y: result = y;
      default:    result = '0;
    endcase
    // Reserved opcodes report all flags clear, including zero.
    flags.zero = (int'(op) <= ALU_PASS_Y) && (result == '0);
  end

endmodule

// File: rtl/pipelined_datapath.sv
// pipelined_datapath: two-stage execution datapath (EX -> WB).
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : instruction handshake
//   op, addr_a, addr_b, addr_d, immed, y_sel, write, wb_sel, ext_data : instruction
//   out_valid, result, flag_zero/carry/ovf : registered ALU result, valid 1 cycle after accept
// Build option: DATAPATH_BYPASS_EN forwards the pending writeback into EX operands
// instead of stalling one cycle on a read-after-write hazard.
module pipelined_datapath
  import datapath_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = $clog2(NREGS),
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   op,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic [DATA_W-1:0] immed,
  input  logic              y_sel,
  input  logic              write,
  input  logic              wb_sel,
  input  logic [DATA_W-1:0] ext_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic              flag_ovf
);

  logic [NREGS-1:0][DATA_W-1:0] rf_q, rf_d;
  logic                         wb_vld_q, wb_vld_d;
  logic                         wb_write_q, wb_write_d;
  logic                         wb_sel_q, wb_sel_d;
  logic [ADDR_W-1:0]            wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]            wb_ext_q, wb_ext_d;
  logic [DATA_W-1:0]            result_q, result_d;
  dp_flags_t                    flags_q, flags_d;

  logic              accept;
  logic              wb_commit;
  logic [DATA_W-1:0] wb_data;
  logic              hz_a, hz_b;
  logic [DATA_W-1:0] x_op, rb_op, y_op;
  logic [DATA_W-1:0] alu_res;
  dp_flags_t         alu_flags;

  // R0 is never written, so a pending write to it is neither a hazard nor forwarded.
  assign wb_commit = wb_vld_q && wb_write_q && (wb_addr_q != '0);
  assign wb_data   = wb_sel_q ? wb_ext_q : result_q;
  assign hz_a      = wb_commit && (addr_a == wb_addr_q);
  assign hz_b      = wb_commit && y_sel && (addr_b == wb_addr_q);

`ifdef DATAPATH_BYPASS_EN
  assign x_op     = hz_a ? wb_data : rf_q[addr_a];
  assign rb_op    = hz_b ? wb_data : rf_q[addr_b];
  assign in_ready = 1'b1;
`else
  assign x_op     = rf_q[addr_a];
  assign rb_op    = rf_q[addr_b];
  // One-cycle stall: WB commits on this edge, so the held instruction reads fresh data next cycle.
  assign in_ready = !(in_valid && (hz_a || hz_b));
`endif

  assign y_op   = y_sel ? rb_op : immed;
  assign accept = in_valid && in_ready;

  dp_alu #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
    .op     (op),
    .x      (x_op),
    .y      (y_op),
    .result (alu_res),
    .flags  (alu_flags)
  );

  always_comb begin
    rf_d       = rf_q;
    if (wb_commit) rf_d[wb_addr_q] = wb_data;
    wb_vld_d   = accept;
    wb_write_d = wb_write_q;
    wb_sel_d   = wb_sel_q;
    wb_addr_d  = wb_addr_q;
    wb_ext_d   = wb_ext_q;
    result_d   = result_q;
    flags_d    = flags_q;
    if (accept) begin
      wb_write_d = write;
      wb_sel_d   = wb_sel;
      wb_addr_d  = addr_d;
      wb_ext_d   = ext_data;
      result_d   = alu_res;
      flags_d    = alu_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_q       <= '0;
      wb_vld_q   <= 1'b0;
      wb_write_q <= 1'b0;
      wb_sel_q   <= 1'b0;
      wb_addr_q  <= '0;
      wb_ext_q   <= '0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      rf_q       <= rf_d;
      wb_vld_q   <= wb_vld_d;
      wb_write_q <= wb_write_d;
      wb_sel_q   <= wb_sel_d;
      wb_addr_q  <= wb_addr_d;
      wb_ext_q   <= wb_ext_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

  assign out_valid  = wb_vld_q;
  assign result     = result_q;
  assign flag_zero  = flags_q.zero;
  assign flag_carry = flags_q.carry;
  assign flag_ovf   = flags_q.ovf;

endmodule

// File: tb/tb_pipelined_datapath.sv
// tb_pipelined_datapath: directed + random instructions checked against a
// sequential (architectural) model of the register file and ALU.
module tb_pipelined_datapath;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = '0;
  logic [4:0]  addr_a = '0, addr_b = '0, addr_d = '0;
  logic [31:0] immed = '0, ext_data = '0;
  logic        y_sel = 1'b0, write = 1'b0, wb_sel = 1'b0;
  logic        out_valid;
  logic [31:0] result;
  logic        flag_zero, flag_carry, flag_ovf;

  pipelined_datapath dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .addr_a(addr_a), .addr_b(addr_b), .addr_d(addr_d),
    .immed(immed), .y_sel(y_sel), .write(write), .wb_sel(wb_sel),
    .ext_data(ext_data), .out_valid(out_valid), .result(result),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_ovf(flag_ovf)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0;
  logic [31:0] ref_rf [32];
  bit          prev_adj = 0, prev_wr = 0;
  int          prev_d = 0;
  logic [31:0] obs_res;
  logic [2:0]  obs_flg;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ALU in plain integer arithmetic; flags returned as {zero, carry, ovf}.
  function automatic void ref_alu(input int opv, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [2:0] f);
    longint ux = x, uy = y;
    longint sx = $signed(x), sy = $signed(y);
    longint t, maxs = 2147483647;
    int     amt = int'(y % 32);
    logic   c = 0, v = 0;
    case (opv)
      0: begin r = x + y; c = (ux + uy) > 64'hFFFF_FFFF; t = sx + sy; v = (t > maxs) || (t < -maxs - 1); end
      1: begin r = x - y; c = (ux >= uy); t = sx - sy; v = (t > maxs) || (t < -maxs - 1); end
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = x << amt;
      6: r = x >> amt;
      7: r = 32'(sx >>> amt);
      8: r = (sx < sy) ? 32'd1 : 32'd0;
      9: r = (ux < uy) ? 32'd1 : 32'd0;
      10: r = y;
      default: r = 0;
    endcase
    f = {(opv <= 10) && (r == 0), c, v};
  endfunction

  // Issue one instruction (holding it through any stall) and check its result.
  task automatic send(input int opv, input int a, input int b, input int d, input logic [31:0] imm,
                      input bit ys, input bit wr, input bit wbs, input logic [31:0] ext);
    logic [31:0] x, y, r;
    logic [2:0]  f;
    int          stalls = 0;
    bit          exp_hz;
    x = ref_rf[a];
    y = ys ? ref_rf[b] : imm;
    ref_alu(opv, x, y, r, f);
    exp_hz = prev_adj && prev_wr && (prev_d != 0) && (a == prev_d || (ys && b == prev_d));
    op = 4'(opv); addr_a = 5'(a); addr_b = 5'(b); addr_d = 5'(d);
    immed = imm; y_sel = ys; write = wr; wb_sel = wbs; ext_data = ext;
    in_valid = 1'b1;
    #1;
    while (!in_ready && stalls < 4) begin
      @(posedge clk); #2;
      stalls++;
    end
`ifdef DATAPATH_BYPASS_EN
    chk("stall_cycles", 64'(stalls), 64'd0);
`else
    chk("stall_cycles", 64'(stalls), 64'(exp_hz));
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("out_valid", 64'(out_valid), 64'd1);
    chk("result", 64'(result), 64'(r));
    chk("flags", 64'({flag_zero, flag_carry, flag_ovf}), 64'(f));
    obs_res = result;
    obs_flg = {flag_zero, flag_carry, flag_ovf};
    if (wr && d != 0) ref_rf[d] = wbs ? ext : r;
    prev_adj = 1; prev_wr = wr; prev_d = d;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    prev_adj = 0;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;
    prev_adj = 0;
  endtask

  initial begin
    reset_model();
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_result", 64'(result), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD with immediate, then carry/zero wrap
    send(0, 1, 0, 2, 32'hFFFF_FFFF, 0, 1, 0, 0);
    chk("add_ff_res", 64'(obs_res), 64'hFFFF_FFFF);
    chk("add_ff_flg", 64'(obs_flg), 64'b000);
    send(0, 2, 0, 7, 32'd1, 0, 1, 0, 0);
    chk("add_wrap_res", 64'(obs_res), 64'd0);
    chk("add_wrap_flg", 64'(obs_flg), 64'b110);
    // SUB overflow
    send(0, 0, 0, 3, 32'h8000_0000, 0, 1, 0, 0);
    idle();
    send(1, 3, 0, 9, 32'd1, 0, 0, 0, 0);
    chk("sub_ovf_res", 64'(obs_res), 64'h7FFF_FFFF);
    chk("sub_ovf_flg", 64'(obs_flg), 64'b011);
    // back-to-back dependency
    send(0, 0, 0, 4, 32'd7, 0, 1, 0, 0);
    send(0, 4, 4, 5, 32'd0, 1, 1, 0, 0);
    chk("dep_res", 64'(obs_res), 64'd14);
    // writes to R0 are dropped; ext load writeback
    send(0, 0, 0, 0, 32'h55, 0, 1, 0, 0);
    send(0, 0, 0, 10, 32'd0, 1, 0, 0, 0);
    chk("r0_res", 64'(obs_res), 64'd0);
    send(0, 0, 0, 6, 32'd0, 0, 1, 1, 32'hA5A5_A5A5);
    send(10, 0, 6, 11, 32'd0, 1, 0, 0, 0);
    chk("ext_res", 64'(obs_res), 64'hA5A5_A5A5);
    // shifts / compares / reserved op
    send(0, 0, 0, 8, 32'h8000_0000, 0, 1, 0, 0);
    send(7, 8, 0, 12, 32'd36, 0, 0, 0, 0);
    chk("sra_res", 64'(obs_res), 64'hF800_0000);
    send(0, 0, 0, 9, 32'hFFFF_FFFF, 0, 1, 0, 0);
    idle();
    send(8, 9, 0, 0, 32'd1, 0, 0, 0, 0);
    chk("slt_res", 64'(obs_res), 64'd1);
    send(9, 9, 0, 0, 32'd1, 0, 0, 0, 0);
    chk("sltu_res", 64'(obs_res), 64'd0);
    send(13, 9, 0, 0, 32'd0, 0, 0, 0, 0);
    chk("rsvd_res", 64'(obs_res), 64'd0);
    chk("rsvd_flg", 64'(obs_flg), 64'b000);

    // reset while a write to R5 is pending WB
    send(0, 0, 0, 5, 32'h1234, 0, 1, 0, 0);
    rst_n = 1'b0;
    #2;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_result", 64'(result), 64'd0);
    reset_model();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send(10, 0, 5, 0, 32'd0, 1, 0, 0, 0);
    chk("midrst_r5", 64'(obs_res), 64'd0);

    // randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 200; i++) begin
      send(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), $urandom, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_datapath.md
Name: pipelined_datapath

Overview:
- Parametrised two-stage execution datapath: register file, operand-select mux, multi-op ALU, writeback stage.
- Accepts one instruction per cycle via a valid/ready handshake.
- Produces a registered ALU result with flags, and writes the register file one cycle later.
- Sits between the instruction decoder and the memory/load unit in the core.

Parameters:
- DATA_W, 32, datapath and register width.
- NREGS, 32, number of architectural registers; power of two ≥ 2.
- ADDR_W, $clog2(NREGS), register address width (derived; do not override).
- OP_W, 4, ALU opcode width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  datapath can accept an instruction this cycle.
- op  in  OP_W  ALU operation.
- addr_a  in  ADDR_W  source register for X operand.
- addr_b  in  ADDR_W  source register for Y operand when y_sel=1.
- addr_d  in  ADDR_W  destination register.
- immed  in  DATA_W  immediate, used as Y when y_sel=0.
- y_sel  in  1  0 = immed, 1 = register b.
- write  in  1  instruction writes addr_d.
- wb_sel  in  1  0 = write ALU result, 1 = write ext_data.
- ext_data  in  DATA_W  external (load) data for writeback.
- out_valid  out  1  result/flags valid.
- result  out  DATA_W  registered ALU result.
- flag_zero  out  1  result == 0.
- flag_carry  out  1  carry-out (ADD) / not-borrow (SUB); 0 otherwise.
- flag_ovf  out  1  signed overflow (ADD/SUB); 0 otherwise.

Behaviour:
- Reset (async assert, sync release): all registers cleared to 0. Outputs: out_valid=0, result=0, all flags=0, in_ready=1. An in-flight writeback is discarded.
- Register 0 always reads 0; writes to it are ignored and never bypassed.
- Accept: a transfer occurs when in_valid && in_ready.
- EX stage (accept cycle):
  - Register read is combinational: X = R[addr_a]; Y = y_sel ? R[addr_b] : immed.
  - The ALU is combinational. On the accept edge, result, flags, addr_d, write, wb_sel and ext_data are captured into the EX/WB register, and out_valid=1 the next cycle.
  - With no accept, out_valid=0 and result/flags hold their last value.
- WB stage: on the edge after capture, if valid && write && addr_d != 0, then R[addr_d] <= wb_sel ? ext_data : result.
  - Latency: result is visible 1 cycle after accept; the register file is updated 2 edges after accept.
- Hazard: the EX instruction reads (addr_a, or addr_b with y_sel=1) a nonzero register that equals the pending WB addr_d with write=1. Handling is defined under Optional Feature.
- ALU op encoding (shared package):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA: shift amount = Y[$clog2(DATA_W)-1:0].
  - 8 SLT (signed, result 0/1), 9 SLTU, 10 PASS_Y.
  - 11..15: result = 0, all flags 0.
- Arithmetic is modulo 2^DATA_W. Carry comes from the DATA_W+1-bit sum. SUB computes X + ~Y + 1.
- No output backpressure: a consumer must sample result whenever out_valid=1.

Optional Feature:
- Macro DATAPATH_BYPASS_EN.
- Defined: on a hazard, the WB writeback value is forwarded to the matching operand(s) in the same cycle. in_ready stays 1, giving full throughput.
- Undefined: on a hazard, in_ready=0 for exactly one cycle; the instruction is held by the sender and accepted on the next cycle, after WB has committed. No forwarding mux is built.

Decomposition:
- Package datapath_pkg: ALU opcode localparams (ALU_ADD..ALU_PASS_Y), flag bundle struct.
- One sub-module: dp_alu, purely combinational, parameterised by DATA_W. It produces result and flags.
- The register file, hazard logic and pipeline registers live in pipelined_datapath.

Test Plan:
- Reset mid-stream: assert rst_n=0 while a write to R5 is pending WB -> R5 reads 0 after release; out_valid=0; in_ready=1.
- ADD immed: R1=0 (reset), op=ADD, y_sel=0, immed=0xFFFFFFFF, addr_d=2 -> next cycle result=0xFFFFFFFF, carry=0, zero=0. Then ADD R2 + immed 1 -> result=0, carry=1, zero=1.
- SUB overflow: R3=0x80000000, SUB Y=immed 1 -> result=0x7FFFFFFF, ovf=1, carry=1.
- Back-to-back dependency: ADD R4=R0+7, then ADD R5=R4+R4 (y_sel=1) -> result=14. With bypass, in_ready never drops; without bypass, in_ready=0 for one cycle and result appears one cycle later.
- Writes to R0 and ext load: write=1, addr_d=0, result 0x55 -> R0 still reads 0, no bypass. wb_sel=1, ext_data=0xA5A5A5A5, addr_d=6 -> R6=0xA5A5A5A5.
- Shift/compare: SRA X=0x80000000, Y=immed 36 (amount 4) -> 0xF8000000. SLT 0xFFFFFFFF vs 1 -> 1; SLTU -> 0. op=13 -> result 0.
